// File: rtl/wb_mem_arbiter.sv
// Two-master (SerV ibus/dbus) to one-slave Wishbone arbiter for the SPI memory port.
// Define ARB_IBUF_EN to add a one-entry instruction read buffer in front of the slave.
module wb_mem_arbiter #(
  parameter int unsigned AW        = 14,
  parameter bit          DBUS_PRIO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cyc,
  input  logic [AW-1:0] i_adr,
  output logic [31:0]   i_rdt,
  output logic          i_ack,
  input  logic          d_cyc,
  input  logic [AW-1:0] d_adr,
  input  logic          d_we,
  input  logic [31:0]   d_dat,
  input  logic [3:0]    d_sel,
  output logic [31:0]   d_rdt,
  output logic          d_ack,
  output logic          m_cyc,
  output logic [AW-1:0] m_adr,
  output logic          m_we,
  output logic [31:0]   m_dat,
  output logic [3:0]    m_sel,
  input  logic [31:0]   m_rdt,
  input  logic          m_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t state;
  logic   d_win;
  logic   i_win;

  always_comb begin
    d_win = d_cyc & (DBUS_PRIO | ~i_cyc);
    i_win = i_cyc & ~d_win;
  end

`ifdef ARB_IBUF_EN
  logic          buf_valid;
  logic [AW-1:0] buf_tag;
  logic [31:0]   buf_data;
  logic          buf_hit;

  always_comb buf_hit = buf_valid && (buf_tag == i_adr);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_cyc <= 1'b0;
      m_adr <= '0;
      m_we  <= 1'b0;
      m_dat <= '0;
      m_sel <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_rdt <= '0;
      d_rdt <= '0;
`ifdef ARB_IBUF_EN
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            m_adr <= d_adr;
            m_we  <= d_we;
            m_dat <= d_dat;
            m_sel <= d_sel;
            m_cyc <= 1'b1;
            state <= BUSY_D;
          end else if (i_win) begin
`ifdef ARB_IBUF_EN
            if (buf_hit) begin
              i_rdt <= buf_data;
              i_ack <= 1'b1;
              state <= RESP;
            end else
`endif
            begin
              m_adr <= i_adr;
              m_we  <= 1'b0;
              m_sel <= '1;
              m_cyc <= 1'b1;
              state <= BUSY_I;
            end
          end
        end
        // m_cyc drops on the acking edge so the slave cannot start a second transfer
        BUSY_I: begin
          if (m_ack) begin
            m_cyc <= 1'b0;
            i_rdt <= m_rdt;
            i_ack <= 1'b1;
            state <= RESP;
`ifdef ARB_IBUF_EN
            buf_valid <= 1'b1;
            buf_tag   <= m_adr;
            buf_data  <= m_rdt;
`endif
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            m_cyc <= 1'b0;
            d_rdt <= m_rdt;
            d_ack <= 1'b1;
            state <= RESP;
`ifdef ARB_IBUF_EN
            if (m_we && (m_adr == buf_tag))
              buf_valid <= 1'b0;
`endif
          end
        end
        // The served master still holds cyc here; arbitrating now would replay it
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
